// File: rtl/tdp_ram_pkg.sv
// True dual-port RAM shared types.
// Read-during-write modes and address helpers.
package tdp_ram_pkg;

    typedef enum logic [1:0] {
        READ_FIRST,
        WRITE_FIRST,
        NO_CHANGE
    } read_mode_e;

    function automatic logic addr_in_range(
        input int unsigned addr,
        input int unsigned depth
    );
        return addr < depth;
    endfunction

endpackage

// File: rtl/true_dual_port_ram_if.sv
// Two-port RAM bus bundle.
// Master drives accesses, slave returns data and flags.
interface tdp_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              en_a_i;
    logic              we_a_i;
    logic [ADDR_W-1:0] addr_a_i;
    logic [DATA_W-1:0] data_a_i;
    logic [DATA_W-1:0] data_a_o;
    logic              valid_a_o;
    logic              en_b_i;
    logic              we_b_i;
    logic [ADDR_W-1:0] addr_b_i;
    logic [DATA_W-1:0] data_b_i;
    logic [DATA_W-1:0] data_b_o;
    logic              valid_b_o;
    logic              collision_o;

    modport master (
        output en_a_i, we_a_i, addr_a_i, data_a_i,
        output en_b_i, we_b_i, addr_b_i, data_b_i,
        input  data_a_o, valid_a_o,
        input  data_b_o, valid_b_o,
        input  collision_o
    );

    modport slave (
        input  en_a_i, we_a_i, addr_a_i, data_a_i,
        input  en_b_i, we_b_i, addr_b_i, data_b_i,
        output data_a_o, valid_a_o,
        output data_b_o, valid_b_o,
        output collision_o
    );
endinterface

// File: rtl/tdp_ram_port.sv
// One RAM read port: read-during-write select,
// output register and optional pipeline stage.
module tdp_ram_port
    import tdp_ram_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter read_mode_e READ_MODE = READ_FIRST,
    parameter int         OUT_REG   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic              upd;
    logic [DATA_W-1:0] s1_data_d;
    logic [DATA_W-1:0] s1_data_q;
    logic              s1_valid_q;

    // Pick the word this access reports, or suppress it.
    always_comb begin
        upd       = en;
        s1_data_d = rdata;
        if (en && we) begin
            unique case (READ_MODE)
                WRITE_FIRST: s1_data_d = wdata;
                NO_CHANGE:   upd       = 1'b0;
                default:     s1_data_d = rdata;
            endcase
        end
    end

    // First output register; holds data when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= upd;
            if (upd) begin
                s1_data_q <= s1_data_d;
            end
        end
    end

    if (OUT_REG != 0) begin : g_pipe
        logic [DATA_W-1:0] s2_data_q;
        logic              s2_valid_q;

        // Extra stage; drains even while the port is idle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign data_o  = s2_data_q;
        assign valid_o = s2_valid_q;
    end else begin : g_direct
        assign data_o  = s1_data_q;
        assign valid_o = s1_valid_q;
    end

endmodule

// File: rtl/true_dual_port_ram.sv
// True dual-port RAM: storage, port-A-priority
// write arbitration and the collision flag.
module true_dual_port_ram
    import tdp_ram_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = $clog2(DEPTH),
    parameter read_mode_e READ_MODE = READ_FIRST,
    parameter int         OUT_REG   = 0
) (
    input logic     clk_i,
    input logic     rst_ni,
    tdp_ram_if.slave bus
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              run_q;
    logic              coll_q;

    logic              acc_a;
    logic              acc_b;
    logic              in_a;
    logic              in_b;
    logic              wr_a;
    logic              wr_b;
    logic              same;
    logic              coll_d;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign acc_a = run_q & bus.en_a_i;
    assign acc_b = run_q & bus.en_b_i;
    assign in_a  = addr_in_range(32'(bus.addr_a_i), DEPTH);
    assign in_b  = addr_in_range(32'(bus.addr_b_i), DEPTH);
    assign same  = bus.addr_a_i == bus.addr_b_i;

    assign wr_a   = acc_a & bus.we_a_i & in_a;
    assign coll_d = wr_a & acc_b & bus.we_b_i & in_b & same;
    assign wr_b   = acc_b & bus.we_b_i & in_b & ~coll_d;

    assign rd_a = in_a ? mem_q[bus.addr_a_i] : '0;
    assign rd_b = in_b ? mem_q[bus.addr_b_i] : '0;

    // Ignore the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Storage; A wins when both hit one word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_a) begin
                mem_q[bus.addr_a_i] <= bus.data_a_i;
            end
            if (wr_b) begin
                mem_q[bus.addr_b_i] <= bus.data_b_i;
            end
        end
    end

    // One-cycle collision pulse, never pipelined.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign bus.collision_o = coll_q;

    tdp_ram_port #(
        .DATA_W   (DATA_W),
        .READ_MODE(READ_MODE),
        .OUT_REG  (OUT_REG)
    ) u_port_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (acc_a),
        .we     (bus.we_a_i & in_a),
        .wdata  (bus.data_a_i),
        .rdata  (rd_a),
        .data_o (bus.data_a_o),
        .valid_o(bus.valid_a_o)
    );

    tdp_ram_port #(
        .DATA_W   (DATA_W),
        .READ_MODE(READ_MODE),
        .OUT_REG  (OUT_REG)
    ) u_port_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (acc_b),
        .we     (bus.we_b_i & in_b),
        .wdata  (bus.data_b_i),
        .rdata  (rd_b),
        .data_o (bus.data_b_o),
        .valid_o(bus.valid_b_o)
    );

endmodule

// File: doc/true_dual_port_ram.md
Name: true_dual_port_ram

Overview:
Parametrised true dual-port RAM, the successor to the 4x1-bit simple dual-port RAM.
- Both ports read and write independently on one clock.
- Width, depth, per-port read-during-write mode and an optional output pipeline stage are configurable.
- Both ports have valid strobes and a write-collision flag.
- Sits as the generic storage primitive under FIFOs and register files in the memory library.

Parameters:
DATA_W, 8, data width per word in bits (>=1)
DEPTH, 16, number of words (>=2, any value, need not be a power of two)
ADDR_W, $clog2(DEPTH), address width, derived, never overridden
READ_MODE, READ_FIRST, own-port read-during-write behaviour: READ_FIRST, WRITE_FIRST or NO_CHANGE
OUT_REG, 0, 1 adds one output pipeline register per port

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
en_a_i  input  1  port A access enable
we_a_i  input  1  port A write enable, qualified by en_a_i
addr_a_i  input  ADDR_W  port A word address
data_a_i  input  DATA_W  port A write data
data_a_o  output  DATA_W  port A read data
valid_a_o  output  1  port A data_a_o updated this cycle
en_b_i, we_b_i, addr_b_i, data_b_i, data_b_o, valid_b_o  same as port A, for port B
collision_o  output  1  registered pulse: both ports wrote the same address

Behaviour:
Reset (rst_ni low, asynchronous)
- All words = 0; data_a_o/data_b_o = 0; valid_*_o = 0; collision_o = 0; pipeline registers = 0.
- An access in the cycle rst_ni deasserts is ignored. The first accepted edge is the one after rst_ni has been sampled high.
- Reset mid-operation discards in-flight pipeline data; no valid pulse is produced for it.

Access rules
- Access on port X = en_X high at the clock edge.
- Write = en & we: mem[addr] <= data at that edge.
- Out-of-range address (addr >= DEPTH): write dropped, read returns 0, valid still pulses.

Read latency
- 1 cycle when OUT_REG=0, 2 cycles when OUT_REG=1.
- valid_X_o pulses high for exactly the cycle data_X_o presents the result of that access.

Own-port read-during-write (READ_MODE)
- READ_FIRST: data_o = old word, valid pulses.
- WRITE_FIRST: data_o = data_i, valid pulses.
- NO_CHANGE: data_o holds its previous value and valid stays low.
- Pure read (we=0): data_o = mem[addr], valid pulses, in all modes.

Cross-port read of a word written the same cycle by the other port
- Always returns the old word, independent of READ_MODE.

Write collision
- Both ports write the same in-range address in one cycle: port A data is stored, port B write is discarded.
- collision_o = 1 for exactly the next cycle.
- Collision checks are not pipelined by OUT_REG.

Idle port (en low)
- data_o holds its value; valid = 0; with OUT_REG=1 the pipeline still drains.

Back-to-back accesses
- Every cycle is supported: throughput is one access per port per cycle, no stalls.

Decomposition:
Package tdp_ram_pkg:
- read_mode_e enum {READ_FIRST, WRITE_FIRST, NO_CHANGE}.
- function addr_in_range(addr, depth).

Sub-module tdp_ram_port, instantiated twice:
- Parameters DATA_W, READ_MODE, OUT_REG.
- Takes en, we, wdata and the raw mem word.
- Produces the registered data_o/valid_o, including the OUT_REG stage.

The top level owns the storage array, the write arbitration (A priority) and collision_o.

Test Plan:
1. DEPTH=16, DATA_W=8, OUT_REG=0, READ_FIRST. A writes 0x5A @3; next cycle B reads @3 -> data_b_o=0x5A, valid_b_o=1 one cycle after the read edge.
2. Own-port read-during-write at @7 (old 0x11, new 0x22), run once per mode: READ_FIRST -> data_a_o=0x11, valid=1; WRITE_FIRST -> 0x22, valid=1; NO_CHANGE -> data_a_o unchanged, valid=0.
3. Collision: A writes 0xAA @5 and B writes 0xBB @5 in the same cycle -> collision_o=1 for one cycle; a later read @5 on either port returns 0xAA.
4. Cross-port: A writes 0x33 @2 (old 0x00) while B reads @2 in the same cycle -> data_b_o=0x00; B re-reads @2 next cycle -> 0x33.
5. OUT_REG=1: B reads @0..@3 on four consecutive cycles -> valid_b_o high for four consecutive cycles starting 2 cycles after the first read edge, data in address order.
6. Reset and range: pull rst_ni low mid-burst with OUT_REG=1 -> all outputs 0 asynchronously, no stale valid after release, a read @9 returns 0. With DEPTH=12, write @13 is dropped and a read @13 returns 0 with valid=1.
